// File: rtl/stepper_move_ctrl.sv
// stepper_move_ctrl
//   Move sequencer placed in front of the dual stepper phase driver. Takes one
//   move command (direction + step count per motor) over valid/ready, drives
//   the driver's 2-bit direction codes for exactly the commanded number of step
//   periods, then returns both codes to stop and pulses done.
//
// Ports
//   clk                      system clock, rising edge
//   reset                    asynchronous, active-high reset
//   cmd_valid / cmd_ready    command handshake (ready only in IDLE)
//   cmd_dir0 / cmd_steps0    motor 0 direction (0 stop, 1 fwd, 2 rev, 3 illegal) and step count
//   cmd_dir1 / cmd_steps1    motor 1 direction and step count
//   abort                    terminate the running move
//   direccion / direccion2   registered direction codes to the driver
//   busy                     high while a move is running
//   done                     one-cycle pulse when a move ends
//   steps_left0/1            remaining steps per motor
module stepper_move_ctrl #(
    parameter int unsigned STEP_DIV = 100000,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_dir0,
    input  logic [CNT_W-1:0] cmd_steps0,
    input  logic [1:0]       cmd_dir1,
    input  logic [CNT_W-1:0] cmd_steps1,
    input  logic             abort,
    output logic [1:0]       direccion,
    output logic [1:0]       direccion2,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] steps_left0,
    output logic [CNT_W-1:0] steps_left1
);

    localparam int unsigned TW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [1:0]       dir_q0, dir_q1;
    logic [1:0]       dir_n0, dir_n1;
    logic [TW-1:0]    tick_cnt;
    logic             tick, accept;
    logic [CNT_W-1:0] load0, load1;
    logic [CNT_W-1:0] next0, next1;

    assign accept = cmd_valid && (state == IDLE);
    assign tick   = (state == RUN) && (tick_cnt == TW'(STEP_DIV - 1));

    // Stop and illegal directions turn that motor's move into a zero-length one.
    always_comb begin
        load0 = ((cmd_dir0 == 2'd1) || (cmd_dir0 == 2'd2)) ? cmd_steps0 : '0;
        load1 = ((cmd_dir1 == 2'd1) || (cmd_dir1 == 2'd2)) ? cmd_steps1 : '0;
    end

    // Next remaining-step values; the direction registers are computed from
    // these so the codes change on the same edge the counts do.
    always_comb begin
        next0  = steps_left0;
        next1  = steps_left1;
        dir_n0 = dir_q0;
        dir_n1 = dir_q1;
        if (accept) begin
            next0  = load0;
            next1  = load1;
            dir_n0 = cmd_dir0;
            dir_n1 = cmd_dir1;
        end else if (state == RUN) begin
            if (abort) begin
                next0 = '0;
                next1 = '0;
            end else if (tick) begin
                if (steps_left0 != '0) next0 = steps_left0 - CNT_W'(1);
                if (steps_left1 != '0) next1 = steps_left1 - CNT_W'(1);
            end
        end
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept)
                      state_nxt = ((load0 == '0) && (load1 == '0)) ? DONE : RUN;
            RUN:  if (abort || ((steps_left0 == '0) && (steps_left1 == '0)))
                      state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        cmd_ready = (state == IDLE);
        busy      = (state == RUN);
        done      = (state == DONE);
    end

    // Datapath: counters, latched directions, registered driver codes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            steps_left0 <= '0;
            steps_left1 <= '0;
            dir_q0      <= '0;
            dir_q1      <= '0;
            direccion   <= '0;
            direccion2  <= '0;
            tick_cnt    <= '0;
        end else begin
            steps_left0 <= next0;
            steps_left1 <= next1;
            dir_q0      <= dir_n0;
            dir_q1      <= dir_n1;
            direccion   <= (next0 != '0) ? dir_n0 : 2'd0;
            direccion2  <= (next1 != '0) ? dir_n1 : 2'd0;
            if (state == RUN && !tick) tick_cnt <= tick_cnt + TW'(1);
            else                       tick_cnt <= '0;
        end
    end

endmodule
